// File: rtl/pokey_mix_pkg.sv
// Shared constants for the POKEY audio mixer slice.
package pokey_mix_pkg;

  localparam int LEVEL_W      = 6;
  localparam int MAX_LEVEL    = 60;
  localparam int NUM_CHANNELS = 4;
  localparam int VOL_W        = 4;

  // Channel bits plus volumes, carried through one synchronizer
  localparam int SYNC_W = NUM_CHANNELS * (VOL_W + 1);

endpackage

// File: rtl/pokey_sync_vec.sv
// Parameterised multi-bit flip-flop synchronizer.
// Every bit is resynchronised independently. This is safe for the mixer
// because the volumes are quasi-static and the audio bits are single-bit
// toggles.
module pokey_sync_vec #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 2
) (
  input  logic             clk179,
  input  logic             init_L,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain_p [DEPTH];

  // Shift the raw inputs through DEPTH register stages
  always_ff @(posedge clk179) begin
    if (!init_L) begin
      for (int i = 0; i < DEPTH; i++) chain_p[i] <= '0;
    end else begin
      chain_p[0] <= d;
      for (int i = 1; i < DEPTH; i++) chain_p[i] <= chain_p[i-1];
    end
  end

  assign q = chain_p[DEPTH-1];

endmodule

// File: rtl/pokey_audio_mixer.sv
// POKEY four-channel audio mixer with a one-bit DAC output.
//
// The mixer sums the gated channel volumes into a 6-bit level and reloads
// that level once per 2^PWM_BITS-cycle period. The level then drives a PWM
// comparator.
//
// Optional build macro POKEY_MIXER_SIGMA_DELTA_EN replaces the comparator
// with a first-order sigma-delta modulator. Counter, level reload and
// sample_stb timing are identical in both builds.
module pokey_audio_mixer
  import pokey_mix_pkg::*;
#(
  parameter int PWM_BITS    = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk179,
  input  logic               init_L,
  input  logic               audio1,
  input  logic               audio2,
  input  logic               audio3,
  input  logic               audio4,
  input  logic [VOL_W-1:0]   vol1,
  input  logic [VOL_W-1:0]   vol2,
  input  logic [VOL_W-1:0]   vol3,
  input  logic [VOL_W-1:0]   vol4,
  input  logic               mute,
  output logic [LEVEL_W-1:0] level,
  output logic               sample_stb,
  output logic               pwm_out
);

  // Clamp a widened sum back into the legal level range
  function automatic logic [LEVEL_W-1:0] sat_level(input logic [LEVEL_W:0] s);
    if (s > (LEVEL_W+1)'(MAX_LEVEL)) return LEVEL_W'(MAX_LEVEL);
    return s[LEVEL_W-1:0];
  endfunction

  // Sum of the volumes whose channel bit is currently high
  function automatic logic [LEVEL_W-1:0] mix_level(
    input logic [NUM_CHANNELS-1:0]       aud,
    input logic [NUM_CHANNELS*VOL_W-1:0] vols
  );
    logic [LEVEL_W:0] s;
    s = '0;
    for (int n = 0; n < NUM_CHANNELS; n++) begin
      if (aud[n]) s = s + (LEVEL_W+1)'(vols[n*VOL_W +: VOL_W]);
    end
    return sat_level(s);
  endfunction

  logic [SYNC_W-1:0]             raw_in;
  logic [SYNC_W-1:0]             sync_q;
  logic [NUM_CHANNELS-1:0]       audio_s;
  logic [NUM_CHANNELS*VOL_W-1:0] vol_s;
  logic [LEVEL_W-1:0]            mix_q;
  logic [PWM_BITS-1:0]           cnt;
  logic [PWM_BITS-1:0]           level_ext;
  logic                          period_end;

  assign raw_in = {vol4, vol3, vol2, vol1, audio4, audio3, audio2, audio1};

  // ---- stage p0: input synchronizer ----
  pokey_sync_vec #(
    .WIDTH (SYNC_W),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk179 (clk179),
    .init_L (init_L),
    .d      (raw_in),
    .q      (sync_q)
  );

  assign audio_s = sync_q[NUM_CHANNELS-1:0];
  assign vol_s   = sync_q[SYNC_W-1:NUM_CHANNELS];

  // ---- stage p1: mix ----
  // Register the gated volume sum every cycle
  always_ff @(posedge clk179) begin
    if (!init_L) mix_q <= '0;
    else         mix_q <= mix_level(audio_s, vol_s);
  end

  // Free-running period counter that wraps at 2^PWM_BITS
  always_ff @(posedge clk179) begin
    if (!init_L) cnt <= '0;
    else         cnt <= cnt + 1'b1;
  end

  assign period_end = &cnt;

  // ---- stage p2: period-boundary level reload ----
  // Mute is sampled only here, so a running period always completes
  always_ff @(posedge clk179) begin
    if (!init_L) begin
      level      <= '0;
      sample_stb <= 1'b0;
    end else begin
      sample_stb <= period_end;
      if (period_end) level <= mute ? '0 : mix_q;
    end
  end

  assign level_ext = PWM_BITS'(level);

  // ---- stage p3: one-bit modulator ----
`ifdef POKEY_MIXER_SIGMA_DELTA_EN
  logic [PWM_BITS:0] acc;

  // First-order sigma-delta: the carry out of the accumulator is the output bit
  always_ff @(posedge clk179) begin
    if (!init_L) begin
      acc     <= '0;
      pwm_out <= 1'b0;
    end else begin
      acc     <= {1'b0, acc[PWM_BITS-1:0]} + {1'b0, level_ext};
      pwm_out <= acc[PWM_BITS];
    end
  end
`else
  // PWM comparator: high for the first `level` counts of each period
  always_ff @(posedge clk179) begin
    if (!init_L) pwm_out <= 1'b0;
    else         pwm_out <= (cnt < level_ext);
  end
`endif

endmodule

// File: tb/tb_pokey_audio_mixer.sv
// Self-checking bench for pokey_audio_mixer.
// The reference model keeps a per-edge history of the ideal channel mix.
// It predicts the level loaded at each period boundary, the strobe position
// and the number of high PWM cycles per period.
module tb_pokey_audio_mixer;

  localparam int PWM_BITS    = 6;
  localparam int SYNC_STAGES = 2;
  localparam int PERIOD      = 1 << PWM_BITS;

  logic       clk179 = 1'b0;
  logic       init_L = 1'b0;
  logic       mute   = 1'b0;
  logic       aud [4];
  logic [3:0] vol [4];
  logic [5:0] level;
  logic       sample_stb;
  logic       pwm_out;

  int errors = 0;
  int checks = 0;

  // Reference state
  int hist[$];         // ideal mix sampled at every clock edge
  int phase     = 0;   // edges since reset, modulo PERIOD
  int exp_level = 0;   // level expected on the output
  int per_prev  = 0;   // level of the period before the current one
  int highs     = 0;   // pwm high samples in the current period

  pokey_audio_mixer #(
    .PWM_BITS    (PWM_BITS),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk179     (clk179),
    .init_L     (init_L),
    .audio1     (aud[0]),
    .audio2     (aud[1]),
    .audio3     (aud[2]),
    .audio4     (aud[3]),
    .vol1       (vol[0]),
    .vol2       (vol[1]),
    .vol3       (vol[2]),
    .vol4       (vol[3]),
    .mute       (mute),
    .level      (level),
    .sample_stb (sample_stb),
    .pwm_out    (pwm_out)
  );

  always #5 clk179 = ~clk179;

  function automatic int mix_ref();
    int s = 0;
    for (int n = 0; n < 4; n++) if (aud[n]) s += int'(vol[n]);
    return s;
  endfunction

  task automatic set_inputs(input int a0, a1, a2, a3, input int v0, v1, v2, v3);
    aud[0] = a0[0]; aud[1] = a1[0]; aud[2] = a2[0]; aud[3] = a3[0];
    vol[0] = v0[3:0]; vol[1] = v1[3:0]; vol[2] = v2[3:0]; vol[3] = v3[3:0];
  endtask

  // Advance one clock edge, update the model, and compare the DUT outputs
  task automatic step();
    int  m, idx, lvl_new;
    bit  rst_edge, bnd, mute_now, ok;
    rst_edge = !init_L;
    m        = rst_edge ? 0 : mix_ref();
    mute_now = mute;
    bnd      = !rst_edge && (phase == PERIOD - 1);
    lvl_new  = exp_level;
    @(posedge clk179);
    hist.push_back(m);
    if (rst_edge) begin
      phase = 0;
    end else begin
      phase = (phase + 1) % PERIOD;
      if (bnd) begin
        idx     = hist.size() - 2 - SYNC_STAGES;
        lvl_new = mute_now ? 0 : ((idx < 0) ? 0 : hist[idx]);
      end
    end
    #1;
    if (rst_edge) begin
      checks++;
      if (pwm_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_pwm: got %0b want 0", pwm_out);
      end
      highs     = 0;
      exp_level = 0;
      per_prev  = 0;
    end else begin
      highs += int'(pwm_out);
    end
    checks++;
    if (sample_stb !== bnd) begin
      errors++;
      $display("FAIL strobe: got %0b want %0b (phase %0d)", sample_stb, bnd, phase);
    end
    if (bnd) begin
`ifdef POKEY_MIXER_SIGMA_DELTA_EN
      ok = (per_prev != exp_level) || (highs >= exp_level - 1 && highs <= exp_level + 1);
`else
      ok = (highs == exp_level);
`endif
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL pwm_density: got %0d high cycles want %0d", highs, exp_level);
      end
      highs     = 0;
      per_prev  = exp_level;
      exp_level = lvl_new;
    end
    checks++;
    if (level !== exp_level[5:0]) begin
      errors++;
      $display("FAIL level: got %0d want %0d", level, exp_level);
    end
  endtask

  task automatic wait_boundary();
    do step(); while (phase != 0);
  endtask

  task automatic wait_phase(input int p);
    do step(); while (phase != p);
  endtask

  task automatic test_reset();
    int  n;
    bit  got;
    set_inputs(1, 1, 1, 1, 15, 15, 15, 15);
    init_L = 1'b0;
    repeat (5) step();
    checks++;
    if (level !== 6'd0 || sample_stb !== 1'b0 || pwm_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got level=%0d stb=%0b pwm=%0b want 0/0/0",
               level, sample_stb, pwm_out);
    end
    init_L = 1'b1;
    n   = 0;
    got = 0;
    while (n < 200 && !got) begin
      step();
      n++;
      if (sample_stb) got = 1;
    end
    checks++;
    if (!got || n != PERIOD) begin
      errors++;
      $display("FAIL first_strobe: got strobe after %0d cycles (seen=%0b) want %0d", n, got, PERIOD);
    end
  endtask

  task automatic test_single_channel();
    set_inputs(1, 0, 0, 0, 10, 0, 0, 0);
    repeat (3) wait_boundary();
    checks++;
    if (level !== 6'd10) begin
      errors++;
      $display("FAIL single_channel: got %0d want 10", level);
    end
  endtask

  task automatic test_full_scale();
    set_inputs(1, 1, 1, 1, 15, 15, 15, 15);
    repeat (3) wait_boundary();
    checks++;
    if (level !== 6'd60) begin
      errors++;
      $display("FAIL full_scale: got %0d want 60", level);
    end
  endtask

  task automatic test_mid_period_change();
    set_inputs(0, 1, 0, 0, 0, 3, 0, 0);
    repeat (2) wait_boundary();
    wait_phase(20);
    vol[1] = 4'd7;
    wait_phase(PERIOD - 1);
    checks++;
    if (level !== 6'd3) begin
      errors++;
      $display("FAIL mid_change_hold: got %0d want 3", level);
    end
    step();
    checks++;
    if (level !== 6'd7 || sample_stb !== 1'b1) begin
      errors++;
      $display("FAIL mid_change_update: got level=%0d stb=%0b want 7/1", level, sample_stb);
    end
    step();
    checks++;
    if (sample_stb !== 1'b0) begin
      errors++;
      $display("FAIL mid_change_pulse: got stb=%0b want 0", sample_stb);
    end
    wait_boundary();
  endtask

  task automatic test_mute();
    set_inputs(1, 1, 0, 0, 15, 15, 0, 0);
    repeat (2) wait_boundary();
    wait_phase(10);
    mute = 1'b1;
    wait_boundary();
    checks++;
    if (level !== 6'd0) begin
      errors++;
      $display("FAIL mute_level: got %0d want 0", level);
    end
    wait_boundary();
    mute = 1'b0;
    repeat (2) wait_boundary();
    checks++;
    if (level !== 6'd30) begin
      errors++;
      $display("FAIL unmute_level: got %0d want 30", level);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      set_inputs($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1),
                 $urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(15));
      mute = ($urandom_range(7) == 0);
      if ($urandom_range(19) == 0) begin
        init_L = 1'b0;
        repeat (4) step();
        init_L = 1'b1;
      end
      repeat ($urandom_range(1, 150)) step();
    end
    mute = 1'b0;
    repeat (2) wait_boundary();
  endtask

  task automatic test_back_to_back();
    // Input changes landing right on the period boundary
    for (int it = 0; it < 8; it++) begin
      wait_phase(PERIOD - 1 - SYNC_STAGES - ($urandom_range(2)));
      set_inputs($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1),
                 $urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(15));
    end
    repeat (2) wait_boundary();
  endtask

  initial begin
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_single_channel();
    test_full_scale();
    test_mid_period_change();
    test_mute();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pokey_audio_mixer.md
# pokey_audio_mixer

Receiving end of the POKEY channel-output interface. Consumes the four per-channel audio bits and 4-bit volumes produced by `pokeyaudio` and mixes them into a single 6-bit level. Converts that level into a one-bit PWM stream (or sigma-delta when configured) for an RC-filtered header pin. This replaces the external resistor DAC on the HDR2 volume pins.

## Interface
Parameters:
- PWM_BITS, 6, PWM counter width; period = 2^PWM_BITS clk179 cycles; legal range 6..10
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer; legal range 2..3

Ports:
- clk179  in  1  single clock, 1.79 MHz; all state on posedge
- init_L  in  1  synchronous active-low reset
- audio1..audio4  in  1 each  channel output bits (driven from clk64/clk16 logic, so treated as asynchronous)
- vol1..vol4  in  4 each  channel volumes (asynchronous, quasi-static)
- mute  in  1  forces the sampled level to 0
- level  out  6  currently playing mixed level, 0..60
- sample_stb  out  1  one-cycle pulse when `level` is reloaded
- pwm_out  out  1  one-bit DAC output

The clock is `clk179`. Reset is `init_L`, synchronous and active-low.

## Operation
- **Synchronizer:** all 20 input bits pass through a SYNC_STAGES-deep flip-flop chain. No combinational path exists from inputs to outputs.
- **Mix stage:** mix_q is registered every cycle.
  - mix_q = sum over n of (audio_n_s ? vol_n_s : 0).
  - The sum is 6 bits wide. Maximum is 4×15 = 60, so it cannot overflow.
- **Period counter:** cnt is PWM_BITS wide and increments every cycle. It wraps from 2^PWM_BITS−1 to 0.
- **Sampling:** on the cycle where cnt == all-ones:
  - level <= mute ? 0 : mix_q
  - sample_stb <= 1
  - On all other cycles sample_stb <= 0.
- **PWM:** pwm_out <= (cnt < zero-extended level), registered.
  - Level L gives exactly L high cycles per period.
  - L = 0 means never high.
  - L = 60 with PWM_BITS = 6 gives 60 high and 4 low cycles.
- **Mute:** sampled only at the period boundary. Asserting mute mid-period lets the current period finish unchanged.
- **Reset:** while init_L = 0 at a clock edge, the following are all 0 on the next cycle:
  - cnt, sync chains, mix_q, level, sample_stb, pwm_out, and the sigma-delta accumulator
- **Reset mid-period:** the period is abandoned. After release, the first sample_stb occurs when cnt first reaches all-ones, 2^PWM_BITS cycles after release.

## Timing
- Latency from an input change to mix_q: SYNC_STAGES + 1 cycles.
- Latency from mix_q to level: up to 2^PWM_BITS cycles, because level only reloads at the period boundary.
- level and sample_stb change on the same edge.
- pwm_out reflects (cnt, level) one cycle late.
  - The first pwm_out of a new period, computed with cnt = 0 and the new level, appears on the edge after sample_stb.
- Simultaneous input change and period boundary: the reload uses the old mix_q. The new value is picked up at the next boundary.
- Sample rate at PWM_BITS = 6: 1.79 MHz / 64 ≈ 27.96 kHz.

## Configuration
- Macro: `POKEY_MIXER_SIGMA_DELTA_EN`
- **Defined:** pwm_out is replaced by a first-order sigma-delta modulator.
  - Accumulator acc is PWM_BITS+1 bits.
  - Each cycle: {carry, acc[PWM_BITS-1:0]} <= acc[PWM_BITS-1:0] + level.
  - pwm_out <= carry.
  - The density over any 2^PWM_BITS-cycle window equals level ±1.
  - cnt, level reload and sample_stb are unchanged.
- **Undefined:** PWM comparator behaviour as above; no accumulator is synthesized.

## Structure
- **Package `pokey_mix_pkg`:**
  - `LEVEL_W` = 6
  - `MAX_LEVEL` = 60
  - `NUM_CHANNELS` = 4
  - `VOL_W` = 4
- **Sub-module `pokey_sync_vec`:** parameterised width/depth synchronizer, instantiated once over the 20 concatenated input bits.
- The mixer, counter and modulator stay in `pokey_audio_mixer`.

## Test plan
- **Reset:** hold init_L = 0 for 5 cycles with all inputs active -> level = 0, sample_stb = 0, pwm_out = 0. First sample_stb arrives 64 cycles after release.
- **Single channel:** audio1 = 1, vol1 = 4'hA, others 0 -> after the next boundary level = 10, and exactly 10 high cycles per 64-cycle period.
- **Full scale:** all audio = 1, all vol = 4'hF -> level = 60, 60 high / 4 low per period; no overflow.
- **Mid-period change:** switch vol2 from 3 to 7 at cnt = 20 with audio2 = 1 -> level stays 3 until the boundary, then 7. sample_stb is a single cycle coinciding with the update.
- **Mute:** with mix = 30, assert mute at cnt = 10 -> the current period still has 30 high cycles; the next period has level = 0 and pwm_out stays low.
- **Sigma-delta build:** with `POKEY_MIXER_SIGMA_DELTA_EN` defined and level = 16 -> 16 ±1 ones per 64-cycle window, with no run of ones longer than 1.
